// File: rtl/nibble_word_assembler_pkg.sv
// Shared packed-union word layout: eight 4-bit nibbles overlaid on two 16-bit fields.
// Also defines the FIFO payload and a helper that builds an all-pad word.
package union_pkg;
  localparam int NIB_PER_WORD = 8;
  localparam int NIB_W        = 4;

  typedef struct packed {
    logic [15:0] data1;
    logic [15:0] data2;
  } data_member_t;

  // Nibble i sits in op_2[i], so op1.data2 holds nibbles 3..0.
  typedef union packed {
    data_member_t                          op1;
    bit [NIB_PER_WORD-1:0][NIB_W-1:0]      op_2;
  } word_u;

  typedef struct packed {
    word_u      word;
    logic [3:0] nibs;
    logic       partial;
  } fifo_entry_t;

  function automatic word_u pad_word(input logic [NIB_W-1:0] pad);
    word_u w;
    w.op_2 = {NIB_PER_WORD{pad}};
    return w;
  endfunction
endpackage

// File: rtl/nibble_word_assembler_if.sv
// Nibble-in / word-out handshake bundle for the assembler.
// The master side feeds nibbles and sinks words; the slave side is the assembler.
interface nibble_word_assembler_if #(parameter int CNT_W = 16);
  logic             nib_valid;
  logic             nib_ready;
  logic [3:0]       nib_data;
  logic             nib_last;
  logic             word_valid;
  logic             word_ready;
  logic [15:0]      word_data1;
  logic [15:0]      word_data2;
  logic [3:0]       word_nibs;
  logic             word_partial;
  logic [CNT_W-1:0] words_out;

  modport master (
    output nib_valid, nib_data, nib_last, word_ready,
    input  nib_ready, word_valid, word_data1, word_data2, word_nibs, word_partial, words_out
  );
  modport slave (
    input  nib_valid, nib_data, nib_last, word_ready,
    output nib_ready, word_valid, word_data1, word_data2, word_nibs, word_partial, words_out
  );
endinterface

// File: rtl/nibble_word_assembler_word_fifo.sv
// First-word-fall-through FIFO of assembled words with registered storage.
// When drained, the head output keeps showing the last popped entry.
module word_fifo
  import union_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fifo_entry_t   mem [DEPTH];
  fifo_entry_t   last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= nxt(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/nibble_word_assembler.sv
// Packs a serial nibble stream into 32-bit union words, closing on the 8th nibble
// or on nib_last, and buffers finished words in a small FWFT FIFO.
module nibble_word_assembler
  import union_pkg::*;
#(
  parameter int         DEPTH   = 2,
  parameter logic [3:0] PAD_NIB = 4'h0,
  parameter int         CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_word_assembler_if.slave bus
);
  word_u            acc, acc_nxt;
  logic [2:0]       idx;
  logic [CNT_W-1:0] word_cnt;
  fifo_entry_t      push_entry, head;
  logic             full, empty;
  logic             accept, close, pop;

  // Ready looks only at the registered fill level, never at word_ready.
  assign bus.nib_ready = !full;
  assign accept        = bus.nib_valid && bus.nib_ready;
  assign close         = accept && ((idx == 3'd7) || bus.nib_last);
  assign pop           = bus.word_valid && bus.word_ready;

  always_comb begin
    acc_nxt          = acc;
    acc_nxt.op_2[idx] = bus.nib_data;
    push_entry       = '{word: acc_nxt, nibs: {1'b0, idx} + 4'd1, partial: (idx != 3'd7)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      acc      <= pad_word(PAD_NIB);
      word_cnt <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          idx <= '0;
          acc <= pad_word(PAD_NIB);
        end else begin
          idx <= idx + 1'b1;
          acc <= acc_nxt;
        end
      end
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (close),
    .wr_entry (push_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign bus.word_valid   = !empty;
  assign bus.word_data1   = head.word.op1.data1;
  assign bus.word_data2   = head.word.op1.data2;
  assign bus.word_nibs    = head.nibs;
  assign bus.word_partial = head.partial;
  assign bus.words_out    = word_cnt;
endmodule

// File: tb/tb_nibble_word_assembler.sv
// Scoreboarded bench: expected words are queued as nibbles are driven and
// compared when the assembler presents them.
module tb_nibble_word_assembler;
  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [3:0]  nibs;
    logic        partial;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_word_assembler_if #(.CNT_W(4))  nif ();
  nibble_word_assembler_if #(.CNT_W(16)) pif ();

  nibble_word_assembler #(.DEPTH(2), .PAD_NIB(4'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(nif.slave));
  nibble_word_assembler #(.DEPTH(2), .PAD_NIB(4'hF), .CNT_W(16)) dut_pad (
    .clk(clk), .rst_n(rst_n), .bus(pif.slave));

  exp_t        sb[$];
  logic [31:0] m_acc = 32'h0;
  int          m_idx = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          stall_err = 0;

  task automatic model_nib(input logic [3:0] d, input logic last);
    exp_t e;
    m_acc[4*m_idx +: 4] = d;
    if (m_idx == 7 || last) begin
      e.d1 = m_acc[31:16]; e.d2 = m_acc[15:0];
      e.nibs = 4'(m_idx + 1); e.partial = (m_idx != 7);
      sb.push_back(e);
      m_acc = 32'h0; m_idx = 0;
    end else m_idx++;
  endtask

  // Call at posedge+1; returns at posedge+1 after the nibble is taken.
  task automatic send_nib(input logic [3:0] d, input logic last);
    int t = 0;
    nif.nib_valid = 1'b1; nif.nib_data = d; nif.nib_last = last;
    @(negedge clk);
    while (!nif.nib_ready && t < 100) begin @(negedge clk); t++; end
    if (!nif.nib_ready) stall_err++;
    else model_nib(d, last);
    @(posedge clk); #1;
    nif.nib_valid = 1'b0; nif.nib_last = 1'b0;
  endtask

  task automatic test_reset();
    nif.nib_valid = 0; nif.nib_data = 0; nif.nib_last = 0; nif.word_ready = 0;
    pif.nib_valid = 0; pif.nib_data = 0; pif.nib_last = 0; pif.word_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (nif.word_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", nif.word_valid); else pass_cnt++;
    total_cnt++; if ({nif.word_data1, nif.word_data2} !== 32'h0) $display("FAIL rst_data: got %h required 0", {nif.word_data1, nif.word_data2}); else pass_cnt++;
    total_cnt++; if ({nif.word_nibs, nif.word_partial} !== 5'h0) $display("FAIL rst_nibs: got %h required 0", {nif.word_nibs, nif.word_partial}); else pass_cnt++;
    total_cnt++; if (nif.words_out !== 4'd0) $display("FAIL rst_cnt: got %0d required 0", nif.words_out); else pass_cnt++;
    total_cnt++; if (nif.nib_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", nif.nib_ready); else pass_cnt++;
  endtask

  task automatic test_full_word();
    exp_t e; int t = 0;
    @(posedge clk); #1;
    nif.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_nib(4'(i), 1'b0);
    @(negedge clk);
    while (!nif.word_valid && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (!nif.word_valid || sb.size() == 0) $display("FAIL full_word: valid=%b queued=%0d required a word", nif.word_valid, sb.size());
    else begin
      e = sb.pop_front();
      if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
        $display("FAIL full_word: got %h required %h", {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
      else pass_cnt++;
    end
    total_cnt++; if (nif.word_data1 !== 16'h7654) $display("FAIL full_word_d1: got %h required 7654", nif.word_data1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (nif.words_out !== 4'd1) $display("FAIL full_word_cnt: got %0d required 1", nif.words_out); else pass_cnt++;
    total_cnt++; if (nif.word_valid !== 1'b0) $display("FAIL full_word_empty: got %b required 0", nif.word_valid); else pass_cnt++;
  endtask

  task automatic test_early_close();
    exp_t e; int t = 0;
    @(posedge clk); #1;
    send_nib(4'hA, 1'b0); send_nib(4'hB, 1'b0); send_nib(4'hC, 1'b1);
    @(negedge clk);
    while (!nif.word_valid && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (!nif.word_valid || sb.size() == 0) $display("FAIL early_close: valid=%b queued=%0d required a word", nif.word_valid, sb.size());
    else begin
      e = sb.pop_front();
      if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
        $display("FAIL early_close: got %h required %h", {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (nif.words_out !== 4'd2) $display("FAIL early_close_cnt: got %0d required 2", nif.words_out); else pass_cnt++;
  endtask

  task automatic test_pad_f();
    @(posedge clk); #1;
    pif.nib_valid = 1'b1; pif.nib_data = 4'hA;
    @(posedge clk); #1; pif.nib_data = 4'hB;
    @(posedge clk); #1; pif.nib_data = 4'hC; pif.nib_last = 1'b1;
    @(posedge clk); #1; pif.nib_valid = 1'b0; pif.nib_last = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pif.word_valid, pif.word_data1, pif.word_data2, pif.word_nibs, pif.word_partial} !== {1'b1, 16'hFFFF, 16'hFCBA, 4'd3, 1'b1})
      $display("FAIL pad_f: got %h required %h", {pif.word_valid, pif.word_data1, pif.word_data2, pif.word_nibs, pif.word_partial},
               {1'b1, 16'hFFFF, 16'hFCBA, 4'd3, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    exp_t e; int t; logic [31:0] held;
    @(posedge clk); #1;
    nif.word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_nib(4'(i), 1'b0);
    @(negedge clk);
    total_cnt++; if (nif.nib_ready !== 1'b0) $display("FAIL bp_ready: got %b required 0", nif.nib_ready); else pass_cnt++;
    held = {nif.word_data1, nif.word_data2};
    nif.nib_valid = 1'b1; nif.nib_data = 4'h5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({nif.word_valid, nif.nib_ready, nif.word_data1, nif.word_data2} !== {1'b1, 1'b0, held})
        $display("FAIL bp_stall%0d: got %h required %h", c, {nif.word_valid, nif.nib_ready, nif.word_data1, nif.word_data2}, {1'b1, 1'b0, held});
      else pass_cnt++;
    end
    @(posedge clk); #1;
    nif.nib_valid = 1'b0; nif.word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) for (int i = 0; i < 8; i++) send_nib(4'(3 * i + 1), 1'b0);
      t = 0;
      @(negedge clk);
      while (!nif.word_valid && t < 50) begin @(negedge clk); t++; end
      total_cnt++;
      if (!nif.word_valid || sb.size() == 0) $display("FAIL bp_word%0d: valid=%b queued=%0d required a word", k, nif.word_valid, sb.size());
      else begin
        e = sb.pop_front();
        if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
          $display("FAIL bp_word%0d: got %h required %h", k, {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
        else pass_cnt++;
      end
      if (k == 1) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    total_cnt++; if (nif.words_out !== 4'd5) $display("FAIL bp_cnt: got %0d required 5", nif.words_out); else pass_cnt++;
  endtask

  task automatic test_last_on_8th();
    exp_t e; int t = 0;
    @(posedge clk); #1;
    for (int i = 8; i < 16; i++) send_nib(4'(i), i == 15);
    @(negedge clk);
    while (!nif.word_valid && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (!nif.word_valid || sb.size() == 0) $display("FAIL last8: valid=%b queued=%0d required a word", nif.word_valid, sb.size());
    else begin
      e = sb.pop_front();
      if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
        $display("FAIL last8: got %h required %h", {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (nif.word_valid !== 1'b0) $display("FAIL last8_single: got valid %b required 0", nif.word_valid); else pass_cnt++;
    total_cnt++; if (nif.words_out !== 4'd6) $display("FAIL last8_cnt: got %0d required 6", nif.words_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    exp_t e; int t = 0;
    @(posedge clk); #1;
    nif.word_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_nib(4'(i ^ 5), 1'b0);
    @(negedge clk);
    total_cnt++; if (nif.word_valid !== 1'b1) $display("FAIL rmid_pre: got valid %b required 1", nif.word_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({nif.word_valid, nif.words_out, nif.nib_ready} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL rmid_async: got %b required %b", {nif.word_valid, nif.words_out, nif.nib_ready}, {1'b0, 4'd0, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete(); m_acc = 32'h0; m_idx = 0;
    @(negedge clk);
    total_cnt++;
    if ({nif.word_valid, nif.words_out, nif.nib_ready} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL rmid_post: got %b required %b", {nif.word_valid, nif.words_out, nif.nib_ready}, {1'b0, 4'd0, 1'b1});
    else pass_cnt++;
    @(posedge clk); #1;
    nif.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_nib(4'(15 - i), 1'b0);
    @(negedge clk);
    while (!nif.word_valid && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (!nif.word_valid || sb.size() == 0) $display("FAIL rmid_word: valid=%b queued=%0d required a word", nif.word_valid, sb.size());
    else begin
      e = sb.pop_front();
      if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
        $display("FAIL rmid_word: got %h required %h", {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (nif.words_out !== 4'd1) $display("FAIL rmid_cnt: got %0d required 1", nif.words_out); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    exp_t e; int exp_wo = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sb.delete(); m_acc = 32'h0; m_idx = 0;
    @(posedge clk); #1;
    nif.word_ready = 1'b1;
    for (int c = 0; c < 140; c++) begin
      if (c < 136) begin
        nif.nib_valid = 1'b1; nif.nib_data = 4'(c); nif.nib_last = 1'b0;
        model_nib(4'(c), 1'b0);
      end else nif.nib_valid = 1'b0;
      @(negedge clk);
      if (c < 136) begin
        total_cnt++; if (nif.nib_ready !== 1'b1) $display("FAIL wrap_ready c%0d: got %b required 1", c, nif.nib_ready); else pass_cnt++;
      end
      total_cnt++;
      if (nif.words_out !== 4'(exp_wo)) $display("FAIL wrap_cnt c%0d: got %0d required %0d", c, nif.words_out, exp_wo); else pass_cnt++;
      if (nif.word_valid) begin
        total_cnt++;
        if (sb.size() == 0) $display("FAIL wrap_word c%0d: got unexpected word %h", c, {nif.word_data1, nif.word_data2});
        else begin
          e = sb.pop_front();
          if ({nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial} !== e)
            $display("FAIL wrap_word c%0d: got %h required %h", c, {nif.word_data1, nif.word_data2, nif.word_nibs, nif.word_partial}, e);
          else pass_cnt++;
        end
        exp_wo = (exp_wo + 1) % 16;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total_cnt++; if (nif.words_out !== 4'd1) $display("FAIL wrap_final: got %0d required 1", nif.words_out); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL wrap_drained: got %0d queued required 0", sb.size()); else pass_cnt++;
    total_cnt++; if (stall_err != 0) $display("FAIL nib_stall: got %0d stalled sends required 0", stall_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_close();
    test_pad_f();
    test_backpressure();
    test_last_on_8th();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
